// File: rtl/unipolar_rz_receiver.sv
// Unipolar return-to-zero line decoder: pulse-width bit classification, LSB-first word assembly,
// frame-end detection. Define UNIPOLAR_RZ_RECEIVER_GLITCH_FILTER_EN to drop sub-GLITCH_TIME pulses.
module unipolar_rz_receiver #(
    parameter int unsigned DATA_WIDTH     = 24,
    parameter int unsigned CLOCK_RATE     = 50_000_000,
    parameter real         THRESHOLD_TIME = 0.6e-6,
    parameter real         MAX_HIGH_TIME  = 1.5e-6,
    parameter real         RESET_TIME     = 50e-6,
    parameter real         GLITCH_TIME    = 60e-9,
    parameter bit          INVERT         = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  line_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  frame_end_o,
    output logic                  error_o,
    output logic                  busy_o
);

    localparam int unsigned THRESHOLD_CYC = int'(real'(CLOCK_RATE) * THRESHOLD_TIME);
    localparam int unsigned MAX_HIGH_CYC  = int'(real'(CLOCK_RATE) * MAX_HIGH_TIME);
    localparam int unsigned RESET_CYC     = int'(real'(CLOCK_RATE) * RESET_TIME);
    localparam int unsigned GLITCH_CYC    = int'(real'(CLOCK_RATE) * GLITCH_TIME);
    localparam int unsigned CW            = $clog2(RESET_CYC + 1);
    localparam int unsigned BW            = $clog2(DATA_WIDTH + 1);
`ifdef UNIPOLAR_RZ_RECEIVER_GLITCH_FILTER_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

    state_e                state_q, state_d, prev_q, prev_d;
    logic [1:0]            sync_q;
    logic                  act_q;
    logic [CW-1:0]         cnt_q, cnt_d, saved_q, saved_d, cnt_inc;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d, data_q, data_d;
    logic                  valid_q, valid_d, frame_end_q, frame_end_d, error_q, error_d;
    logic                  act, rise, fall, bit_v;
    logic [CW+1:0]         restore_sum;

    assign act     = sync_q[1] ^ INVERT;
    assign rise    = act & ~act_q;
    assign fall    = ~act & act_q;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign bit_v   = cnt_q >= CW'(THRESHOLD_CYC);
    // Inactive count a filtered glitch would have reached had the line stayed idle.
    assign restore_sum = {2'b00, saved_q} + {2'b00, cnt_q} + (CW + 2)'(2);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        saved_d     = saved_q;
        cnt_d       = (rise | fall) ? '0 : cnt_inc;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_end_d = 1'b0;
        error_d     = 1'b0;
        unique case (state_q)
            StSync: begin
                if (act) begin
                    cnt_d = '0;
                end else if (cnt_q >= CW'(RESET_CYC)) begin
                    state_d = StIdle;
                end
            end
            StIdle, StLow: begin
                if (rise) begin
                    state_d = StHigh;
                    prev_d  = state_q;
                    saved_d = cnt_q;
                end else if (state_q == StLow && cnt_q >= CW'(RESET_CYC)) begin
                    frame_end_d = 1'b1;
                    error_d     = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    sh_d        = '0;
                    state_d     = StIdle;
                end
            end
            StHigh: begin
                if (fall) begin
                    if (GLITCH_EN && cnt_q < CW'(GLITCH_CYC - 1)) begin
                        state_d = prev_q;
                        cnt_d   = (restore_sum[CW+1:CW] != 2'b00) ? '1 : restore_sum[CW-1:0];
                    end else begin
                        state_d = StLow;
                        sh_d    = {bit_v, sh_q[DATA_WIDTH-1:1]};
                        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                            data_d    = sh_d;
                            valid_d   = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else if (cnt_q >= CW'(MAX_HIGH_CYC)) begin
                    error_d   = 1'b1;
                    sh_d      = '0;
                    bit_cnt_d = '0;
                    state_d   = StSync;
                end
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= {2{INVERT}};
            act_q       <= 1'b0;
            state_q     <= StSync;
            prev_q      <= StIdle;
            saved_q     <= '0;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_end_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], line_i};
            act_q       <= act;
            state_q     <= state_d;
            prev_q      <= prev_d;
            saved_q     <= saved_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_end_q <= frame_end_d;
            error_q     <= error_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_end_o = frame_end_q;
    assign error_o     = error_q;
    assign busy_o      = (state_q == StHigh) || (state_q == StLow);

endmodule
